// File: rtl/mmm_sched.sv
// mmm_sched: sequencer for the matrix-multiply datapath
// (input_mems -> mac_pipe -> fifo_out). Walks the M x N result row-major and
// issues one K-long dot product at a time. A dot starts only when the FIFO
// has a free slot for its result, so issue never stalls partway through a dot.
// Optional feature: define MMM_SCHED_PERF_EN to add the stall_cycles output.
module mmm_sched #(
  parameter int M       = 7,
  parameter int N       = 9,
  parameter int MAXK    = 8,
  parameter int MEM_LAT = 1,
  parameter int MAC_LAT = 2,
  localparam int K_BITS = $clog2(MAXK+1),
  localparam int AW     = $clog2(M*MAXK),
  localparam int BW     = $clog2(MAXK*N),
  localparam int CW     = $clog2(N+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              matrices_loaded,
  input  logic [K_BITS-1:0] K,
  output logic              compute_finished,
  output logic [AW-1:0]     A_read_addr,
  output logic [BW-1:0]     B_read_addr,
  output logic              valid_input,
  output logic              clear_acc,
  output logic              fifo_wr_en,
  input  logic [CW-1:0]     fifo_capacity,
  output logic              busy
`ifdef MMM_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int CLW = (N > 1) ? $clog2(N) : 1;
  localparam int WL  = MEM_LAT + MAC_LAT;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state, next_state;

  logic [RW-1:0]      row;
  logic [CLW-1:0]     col;
  logic [K_BITS-1:0]  idx;
  logic [CW-1:0]      outstanding;
  logic [MEM_LAT-1:0] v_pipe, f_pipe;
  logic [WL-1:0]      l_pipe;
  logic [AW-1:0]      a_calc, a_hold;
  logic [BW-1:0]      b_calc, b_hold;
  logic               just_done;
  logic               issue_v, issue_first, issue_last;
  logic               last, final_dot, credit_ok, start, dec, pipes_empty;

  assign last        = (idx == K - K_BITS'(1));
  assign final_dot   = last && (row == RW'(M-1)) && (col == CLW'(N-1));
  // A credit exists while the FIFO has more free slots than results in flight.
  assign credit_ok   = (fifo_capacity > outstanding) && (outstanding != CW'(N));
  assign start       = ((state == S_WAIT) && credit_ok) ||
                       ((state == S_ISSUE) && last && !final_dot && credit_ok);
  // The FIFO's free-slot count drops the cycle after a write; release the credit then too.
  assign dec         = fifo_wr_en && (outstanding != '0);
  assign pipes_empty = (v_pipe == '0) && (f_pipe == '0) && (l_pipe == '0) &&
                       (outstanding == '0);
  assign a_calc      = AW'(row) * AW'(K) + AW'(idx);
  assign b_calc      = BW'(idx) * BW'(N) + BW'(col);
  assign valid_input = v_pipe[MEM_LAT-1];
  assign clear_acc   = f_pipe[MEM_LAT-1];
  assign fifo_wr_en  = l_pipe[WL-1];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a last idx with credit in hand chains straight into the next dot
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (matrices_loaded && !just_done) next_state = (K == '0) ? S_DONE : S_WAIT;
      S_WAIT:  if (credit_ok) next_state = S_ISSUE;
      S_ISSUE: if (last) next_state = final_dot ? S_DRAIN : (credit_ok ? S_ISSUE : S_WAIT);
      S_DRAIN: if (pipes_empty) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Issue strobes, status and address outputs (addresses hold between dots, 0 when idle)
  always_comb begin
    issue_v          = (state == S_ISSUE);
    issue_first      = issue_v && (idx == '0);
    issue_last       = issue_v && last;
    compute_finished = (state == S_DONE);
    busy             = (state != S_IDLE);
    A_read_addr      = a_hold;
    B_read_addr      = b_hold;
    if (state == S_IDLE) begin
      A_read_addr = '0;
      B_read_addr = '0;
    end else if (issue_v) begin
      A_read_addr = a_calc;
      B_read_addr = b_calc;
    end
  end

  // Row/col/idx walk, row-major over the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else if (state == S_IDLE) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else if (state == S_ISSUE) begin
      if (last) begin
        idx <= '0;
        if (col == CLW'(N-1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CLW'(1);
        end
      end else begin
        idx <= idx + K_BITS'(1);
      end
    end
  end

  // Last issued address, held while not issuing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_hold <= '0;
      b_hold <= '0;
    end else if (state == S_IDLE) begin
      a_hold <= '0;
      b_hold <= '0;
    end else if (issue_v) begin
      a_hold <= a_calc;
      b_hold <= b_calc;
    end
  end

  // Alignment delay lines: memory latency for valid/clear, plus MAC latency for the write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_pipe <= '0;
      f_pipe <= '0;
      l_pipe <= '0;
    end else begin
      v_pipe <= (v_pipe << 1) | MEM_LAT'(issue_v);
      f_pipe <= (f_pipe << 1) | MEM_LAT'(issue_first);
      l_pipe <= (l_pipe << 1) | WL'(issue_last);
    end
  end

  // Results in flight that already own a FIFO slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) outstanding <= '0;
    else begin
      unique case ({start, dec})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // input_mems needs a cycle to drop matrices_loaded after a job completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) just_done <= 1'b0;
    else        just_done <= (state == S_DONE);
  end

`ifdef MMM_SCHED_PERF_EN
  // WAIT cycles spent without a credit for the current job, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cycles <= '0;
    else if ((state == S_IDLE) && (next_state == S_WAIT)) stall_cycles <= '0;
    else if ((state == S_WAIT) && !credit_ok && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mmm_sched.sv
// tb_mmm_sched: table of whole-job vectors plus hand sequences for credit
// starvation, async reset mid-job and back-to-back jobs. A scoreboard holds
// the expected A/B address, clear flag and write slot of every product.
module tb_mmm_sched;
  localparam int TM = 2, TN = 2, TMAXK = 8, MEM_LAT = 1, MAC_LAT = 2;
  localparam int KB = $clog2(TMAXK+1);
  localparam int AW = $clog2(TM*TMAXK);
  localparam int BW = $clog2(TMAXK*TN);
  localparam int CW = $clog2(TN+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          matrices_loaded;
  logic [KB-1:0] K;
  logic          compute_finished;
  logic [AW-1:0] A_read_addr;
  logic [BW-1:0] B_read_addr;
  logic          valid_input, clear_acc, fifo_wr_en, busy;
  logic [CW-1:0] fifo_capacity;
`ifdef MMM_SCHED_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  mmm_sched #(.M(TM), .N(TN), .MAXK(TMAXK), .MEM_LAT(MEM_LAT), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset), .matrices_loaded(matrices_loaded), .K(K),
    .compute_finished(compute_finished), .A_read_addr(A_read_addr), .B_read_addr(B_read_addr),
    .valid_input(valid_input), .clear_acc(clear_acc), .fifo_wr_en(fifo_wr_en),
    .fifo_capacity(fifo_capacity), .busy(busy)
`ifdef MMM_SCHED_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; bit first; bit last; } exp_t;
  typedef struct { int k; int cap; int exp_valid; int exp_clear; int exp_wr; int exp_done; } vec_t;

  exp_t sb[$];
  int   wr_q[$];
  vec_t vecs[5];
  int   checks = 0, errors = 0;
  int   cyc = 0, prev_a = 0, prev_b = 0;
  int   n_valid, n_clear, n_wr, n_done;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Expected products of one job, row-major, idx innermost
  task automatic push_dots(input int k, input int ndots);
    int d = 0;
    for (int r = 0; r < TM; r++)
      for (int c = 0; c < TN; c++) begin
        if (d < ndots)
          for (int i = 0; i < k; i++) begin
            exp_t e;
            e.a = r*k + i; e.b = i*TN + c; e.first = (i == 0); e.last = (i == k-1);
            sb.push_back(e);
          end
        d++;
      end
  endtask

  // Called once per cycle at the falling edge
  task automatic sample();
    cyc++;
    if (valid_input) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL product: unexpected valid_input at cycle %0d", cyc);
      end else begin
        exp_t e = sb.pop_front();
        if (prev_a != e.a || prev_b != e.b || clear_acc != e.first) begin
          errors++;
          $display("FAIL product: got A=%0d B=%0d clr=%0b, want A=%0d B=%0d clr=%0b",
                   prev_a, prev_b, clear_acc, e.a, e.b, e.first);
        end
        if (e.last) wr_q.push_back(cyc + MAC_LAT);
      end
    end else if (clear_acc) begin
      checks++; errors++;
      $display("FAIL clear_acc: high without valid_input at cycle %0d", cyc);
    end
    if (fifo_wr_en) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_wr_en: unexpected write at cycle %0d", cyc);
      end else begin
        int w = wr_q.pop_front();
        if (w != cyc) begin
          errors++;
          $display("FAIL fifo_wr_en: got cycle %0d, want cycle %0d", cyc, w);
        end
      end
    end
    n_valid += int'(valid_input);
    n_clear += int'(clear_acc);
    n_wr    += int'(fifo_wr_en);
    n_done  += int'(compute_finished);
    prev_a = int'(A_read_addr);
    prev_b = int'(B_read_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    sample();
  endtask

  task automatic clr_counts();
    n_valid = 0; n_clear = 0; n_wr = 0; n_done = 0;
  endtask

  // Run one job to its compute_finished pulse; lat = cycles from load to pulse
  task automatic run_job(input int k, input int cap, output int lat);
    push_dots(k, TM*TN);
    clr_counts();
    K = KB'(k); fifo_capacity = CW'(cap); matrices_loaded = 1'b1;
    lat = -1;
    for (int t = 1; t <= 600 && lat < 0; t++) begin
      tick();
      if (compute_finished) begin
        lat = t;
        matrices_loaded = 1'b0;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL job_timeout: got no compute_finished, want one (K=%0d)", k);
      matrices_loaded = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    matrices_loaded = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete(); wr_q.delete();
    clr_counts();
  endtask

  initial begin
    int lat;
    bit found;
    vecs[0] = '{3, 2, 12, 4, 4, 1};
    vecs[1] = '{1, 1,  4, 4, 4, 1};
    vecs[2] = '{8, 2, 32, 4, 4, 1};
    vecs[3] = '{2, 1,  8, 4, 4, 1};
    vecs[4] = '{0, 2,  0, 0, 0, 1};

    reset = 1'b0; matrices_loaded = 1'b0; K = '0; fifo_capacity = '0;
    clr_counts();
    #12;
    chk("rst busy", int'(busy), 0);
    chk("rst valid_input", int'(valid_input), 0);
    chk("rst fifo_wr_en", int'(fifo_wr_en), 0);
    chk("rst compute_finished", int'(compute_finished), 0);
    chk("rst addr", int'({A_read_addr, B_read_addr}), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) tick();

    // Whole-job vectors
    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].k, vecs[v].cap, lat);
      repeat (3) tick();
      chk($sformatf("vec%0d valid_input", v), n_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d clear_acc", v), n_clear, vecs[v].exp_clear);
      chk($sformatf("vec%0d fifo_wr_en", v), n_wr, vecs[v].exp_wr);
      chk($sformatf("vec%0d compute_finished", v), n_done, vecs[v].exp_done);
      chk($sformatf("vec%0d leftover products", v), sb.size() + wr_q.size(), 0);
      chk($sformatf("vec%0d busy after", v), int'(busy), 0);
      if (vecs[v].k == 0) begin
        checks++;
        if (lat < 1 || lat > 2) begin
          errors++;
          $display("FAIL k0 latency: got %0d cycles, want 1..2", lat);
        end
      end
    end

    // Back-to-back jobs: reload the cycle after compute_finished drops
    run_job(3, 2, lat);
    chk("b2b job1 fifo_wr_en", n_wr, TM*TN);
    tick();
    run_job(3, 2, lat);
    chk("b2b job2 fifo_wr_en", n_wr, TM*TN);
    chk("b2b job2 valid_input", n_valid, TM*TN*3);
    chk("b2b leftover products", sb.size() + wr_q.size(), 0);
    repeat (3) tick();

    // Credit starvation: nothing issues, then a single one-cycle credit gives one dot
    push_dots(3, 1);
    clr_counts();
    K = KB'(3); fifo_capacity = '0; matrices_loaded = 1'b1;
    repeat (20) tick();
    chk("starve valid_input", n_valid, 0);
    chk("starve busy", int'(busy), 1);
    fifo_capacity = CW'(1);
    tick();
    fifo_capacity = '0;
    repeat (15) tick();
    chk("one-credit valid_input", n_valid, 3);
    chk("one-credit clear_acc", n_clear, 1);
    chk("one-credit fifo_wr_en", n_wr, 1);
    chk("one-credit still waiting", int'(busy), 1);
    chk("one-credit compute_finished", n_done, 0);
    do_reset();
    repeat (2) tick();

    // Async reset during idx=1 of the third dot (row 1, col 0 -> A=4, B=2)
    push_dots(3, TM*TN);
    clr_counts();
    K = KB'(3); fifo_capacity = CW'(2); matrices_loaded = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      tick();
      if (A_read_addr == AW'(4) && B_read_addr == BW'(2)) found = 1'b1;
    end
    chk("third dot reached", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    chk("async rst strobes", int'({valid_input, clear_acc, fifo_wr_en, compute_finished}), 0);
    chk("async rst busy", int'(busy), 0);
    chk("async rst addr", int'({A_read_addr, B_read_addr}), 0);
    matrices_loaded = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete(); wr_q.delete();
    clr_counts();
    repeat (10) tick();
    chk("post-rst busy", int'(busy), 0);
    chk("post-rst compute_finished", n_done, 0);
    chk("post-rst valid_input", n_valid, 0);

`ifdef MMM_SCHED_PERF_EN
    // Seven credit-less WAIT cycles before the first dot
    push_dots(3, 1);
    K = KB'(3); fifo_capacity = '0; matrices_loaded = 1'b1;
    repeat (8) tick();
    fifo_capacity = CW'(1);
    tick();
    fifo_capacity = '0;
    repeat (3) tick();
    chk("stall_cycles", int'(stall_cycles), 7);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
